// File: rtl/data_ram_bus.sv
// Data-side RAM plus MMIO window (GPIO out/in, compare-match timer) for the pipeline CPU.
// Define DMEM_TIMER_EN to build the timer registers and irq_o; otherwise timer offsets read 0.
module data_ram_bus #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic [31:0] gpio_in_i,
    output logic [31:0] gpio_out_o,
    output logic        irq_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       ramMem [DEPTH];
    logic              active;
    logic              isMmio;
    logic              ramWr;
    logic              mmioWr;
    logic [ADDR_W-1:0] wordIdx;
    logic [2:0]        regOff;
    logic [31:0]       gpioOut_q, gpioOut_d;
    logic [31:0]       gpioSync1_q, gpioSync2_q;
    logic [31:0]       cntRd, ctrlRd, cmpRd;
    logic              unusedAddrBits;

    function automatic logic [31:0] laneMerge(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  sel);
        logic [31:0] merged;
        merged = oldVal;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) merged[8*n +: 8] = newVal[8*n +: 8];
        end
        return merged;
    endfunction

    assign active         = |ce_i;
    assign isMmio         = (addr_i[31:28] == 4'h1);
    assign wordIdx        = addr_i[ADDR_W+1:2];
    assign regOff         = addr_i[4:2];
    assign ramWr          = active && we_i && !isMmio && !rst;
    assign mmioWr         = active && we_i && isMmio;
    assign gpio_out_o     = gpioOut_q;
    assign unusedAddrBits = ^{addr_i[27:ADDR_W+2], addr_i[1:0]};

    // RAM has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (ramWr) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_i[n]) ramMem[wordIdx][8*n +: 8] <= wdata_i[8*n +: 8];
            end
        end
    end

    always_comb begin
        gpioOut_d = gpioOut_q;
        if (mmioWr && regOff == 3'd0) gpioOut_d = laneMerge(gpioOut_q, wdata_i, sel_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpioOut_q   <= '0;
            gpioSync1_q <= '0;
            gpioSync2_q <= '0;
        end else begin
            gpioOut_q   <= gpioOut_d;
            gpioSync1_q <= gpio_in_i;
            gpioSync2_q <= gpioSync1_q;
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] timerCnt_q, timerCnt_d;
    logic [31:0] timerCmp_q, timerCmp_d;
    logic        timerEn_q, timerEn_d;
    logic        flag_q, flag_d;
    logic        ie_q, ie_d;
    logic        ctrlWr, runEn, match;

    // A CTRL write with EN=0 stops the count at that same edge; a CNT write beats increment/reload.
    always_comb begin
        ctrlWr     = mmioWr && regOff == 3'd3 && sel_i[0];
        runEn      = timerEn_q && !(ctrlWr && !wdata_i[0]);
        match      = runEn && (timerCnt_q == timerCmp_q);
        timerEn_d  = ctrlWr ? wdata_i[0] : timerEn_q;
        ie_d       = ctrlWr ? wdata_i[2] : ie_q;
        flag_d     = flag_q;
        if (ctrlWr && wdata_i[1]) flag_d = 1'b0;
        if (match) flag_d = 1'b1;
        timerCnt_d = timerCnt_q;
        if (runEn) timerCnt_d = match ? 32'd0 : timerCnt_q + 32'd1;
        if (mmioWr && regOff == 3'd2) timerCnt_d = laneMerge(timerCnt_q, wdata_i, sel_i);
        timerCmp_d = timerCmp_q;
        if (mmioWr && regOff == 3'd4) timerCmp_d = laneMerge(timerCmp_q, wdata_i, sel_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timerCnt_q <= '0;
            timerCmp_q <= '0;
            timerEn_q  <= 1'b0;
            flag_q     <= 1'b0;
            ie_q       <= 1'b0;
        end else begin
            timerCnt_q <= timerCnt_d;
            timerCmp_q <= timerCmp_d;
            timerEn_q  <= timerEn_d;
            flag_q     <= flag_d;
            ie_q       <= ie_d;
        end
    end

    assign cntRd  = timerCnt_q;
    assign ctrlRd = {29'd0, ie_q, flag_q, timerEn_q};
    assign cmpRd  = timerCmp_q;
    assign irq_o  = flag_q && ie_q;
`else
    assign cntRd  = '0;
    assign ctrlRd = '0;
    assign cmpRd  = '0;
    assign irq_o  = 1'b0;
`endif

    always_comb begin
        rdata_o = '0;
        if (active && !rst) begin
            if (isMmio) begin
                case (regOff)
                    3'd0:    rdata_o = gpioOut_q;
                    3'd1:    rdata_o = gpioSync2_q;
                    3'd2:    rdata_o = cntRd;
                    3'd3:    rdata_o = ctrlRd;
                    3'd4:    rdata_o = cmpRd;
                    default: rdata_o = '0;
                endcase
            end else begin
                rdata_o = ramMem[wordIdx];
            end
        end
    end

endmodule

// File: doc/data_ram_bus.md
# data_ram_bus

Data-side memory responder for the five-stage pipeline CPU: it answers the CPU's RAM port (address, write data, write enable, byte select, chip enable) with a word-wide data RAM and a small memory-mapped I/O window. The window holds a GPIO output register, a synchronised GPIO input, and a compare-match timer that raises an interrupt request. It sits beside the CPU at the top level and returns read data combinationally so the MEM stage can forward it to MEM/WB in the same cycle.

## Interface

- ADDR_W, 10, RAM word-address width; RAM depth = 2^ADDR_W words (default 4 KiB).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce_i  in  4  chip enable; an access is active when ce_i != 4'b0000.
- we_i  in  1  1 = write, 0 = read (valid only while active).
- addr_i  in  32  byte address; bits [1:0] ignored.
- sel_i  in  4  byte lanes; sel_i[3] = bits 31:24 (big-endian lane order).
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, combinational.
- gpio_in_i  in  32  asynchronous external inputs.
- gpio_out_o  out  32  GPIO output register.
- irq_o  out  1  timer interrupt request, level.

## Operation

- Decode: addr_i[31:28] == 4'h1 selects MMIO; every other address selects RAM, word index addr_i[ADDR_W+1:2] (aliases modulo depth).
- RAM write: on the clock edge when active, we_i = 1 and RAM selected, each lane with sel_i[n] = 1 is updated; other lanes keep their value. RAM contents are not cleared by rst.
- RAM read: rdata_o = full addressed word, regardless of sel_i; the CPU extracts the bytes it needs.
- MMIO registers (offset = addr_i[4:2]):
  - 0 GPIO_OUT: RW, lane-masked writes.
  - 1 GPIO_IN: RO, output of a 2-flop synchroniser on gpio_in_i.
  - 2 TIMER_CNT: RW. A write loads the count.
  - 3 TIMER_CTRL: bit0 EN, bit1 FLAG (read; write 1 clears), bit2 IE. Other bits read 0.
  - 4 TIMER_CMP: RW.
  - Offsets 5–7: read 0, writes ignored.
- MMIO writes honour sel_i per byte, except the TIMER_CTRL bit fields, which are taken from lane 0 only when sel_i[0] = 1.
- Timer: while EN = 1, TIMER_CNT increments by 1 each cycle.
  - When TIMER_CNT == TIMER_CMP, the next value is 0 (auto-reload) and FLAG sets.
  - 32-bit arithmetic wraps to 0 after 0xFFFFFFFF.
- irq_o = FLAG & IE.
- rdata_o = 0 when no access is active or while rst = 1.

## Timing

- Reset values: gpio_out_o = 0, irq_o = 0, and rdata_o = 0. GPIO_OUT, TIMER_CNT, TIMER_CTRL, TIMER_CMP and the synchroniser flops are all 0 after reset.
- Read latency 0: rdata_o follows addr_i in the same cycle.
- Write latency: the new value is visible on rdata_o in the cycle after the write edge.
- Read and write to the same address in the same cycle: rdata_o shows the old value.
- gpio_in_i change reaches GPIO_IN 2 edges later.
- Simultaneous events:
  - A CPU write to TIMER_CNT overrides both increment and reload in that cycle.
  - A match in the same cycle as a FLAG write-1-to-clear leaves FLAG set (set wins).
  - A write of EN = 0 takes effect at that edge; no increment occurs at that edge.
- FLAG sets at the edge where the count reloads to 0; irq_o rises in that cycle and stays high until cleared or IE = 0.
- rst asserted mid-operation immediately forces all registers to their reset values; a write in flight at that edge is lost.

## Configuration

- DMEM_TIMER_EN defined: timer registers, match logic and irq_o are built as described above.
- DMEM_TIMER_EN undefined: offsets 2–4 read 0 and ignore writes, and irq_o is tied to 0. RAM and GPIO behaviour is unchanged.

## Test plan

- RAM lane writes: write 0x11223344 to 0x00000040 with sel 1111, then 0xAABBCCDD with sel 0101 → next-cycle read returns 0x11BB33DD; a read of 0x00001040 (alias, ADDR_W=10) returns the same word.
- Read-during-write: read and write 0x00000080 in the same cycle with old value 0 → rdata_o = 0 that cycle and the new value the next cycle.
- GPIO: write 0xFF to 0x10000000 with sel 0001 → gpio_out_o = 0x000000FF. Set gpio_in_i = 0xA5A5A5A5 → GPIO_IN reads that value exactly 2 edges later.
- Timer (DMEM_TIMER_EN defined): CMP = 3, CTRL = 0b101 → CNT runs 0,1,2,3,0; FLAG and irq_o rise at the 3→0 edge. Writing CTRL = 0b111 clears FLAG and irq_o falls the next cycle.
- Timer collisions: write CNT = 0x100 in the match cycle → CNT = 0x100 next, FLAG still sets. Clear FLAG in a match cycle → FLAG remains 1.
- Reset: assert rst mid-count with GPIO_OUT = 0xFF → gpio_out_o = 0, irq_o = 0 and rdata_o = 0 immediately; RAM word at 0x40 still holds its value after release.
